// File: rtl/frost_share_engine.sv
// rtl/frost_share_engine.sv - FROST share evaluation (Horner over GF(L)) and share aggregation engine
module frost_share_engine #(
    parameter int NUM_NODES      = 4,
    parameter int THRESHOLD      = 2,
    parameter int SCALAR_BITS    = 253,
    parameter logic [SCALAR_BITS-1:0] MODULUS =
        253'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_eval,
    input  logic                   start_agg,
    input  logic                   abort,
    input  logic                   coeff_wr_en,
    input  logic [7:0]             coeff_wr_idx,
    input  logic [SCALAR_BITS-1:0] coeff_wr_data,
    output logic                   share_out_valid,
    input  logic                   share_out_ready,
    output logic [7:0]             share_out_idx,
    output logic [SCALAR_BITS-1:0] share_out_data,
    input  logic                   share_in_valid,
    output logic                   share_in_ready,
    input  logic [7:0]             share_in_sender,
    input  logic [SCALAR_BITS-1:0] share_in_data,
    output logic                   busy,
    output logic                   eval_done,
    output logic                   agg_done,
    output logic [SCALAR_BITS-1:0] secret_share,
    output logic [NUM_NODES-1:0]   recv_mask,
    output logic [NUM_NODES-1:0]   complaint_mask,
    output logic [3:0]             err
);

    typedef enum logic [2:0] {
        IDLE, EVAL_LOAD, EVAL_MUL, EVAL_ADD, EVAL_OUT, AGG, DONE
    } state_t;

    localparam int KW = (THRESHOLD > 1) ? $clog2(THRESHOLD + 1) : 1;
    localparam logic [SCALAR_BITS:0] MOD_W     = {1'b0, MODULUS};
    localparam logic [7:0]           LAST_J    = 8'(NUM_NODES);
    localparam logic [7:0]           T_IDX     = 8'(THRESHOLD);
    localparam logic [KW-1:0]        K_TOP     = KW'(THRESHOLD - 1);
    localparam logic [31:0]          TIMER_END = 32'(TIMEOUT_CYCLES - 1);

    state_t                 state, state_next;
    logic [SCALAR_BITS-1:0] coeff [0:THRESHOLD];
    logic [SCALAR_BITS-1:0] acc, r, acc_sum;
    logic [7:0]             j;
    logic [KW-1:0]          k;
    logic [2:0]             bit_cnt;
    logic [31:0]            timer;

    logic                   out_hs, in_hs, idle_like;
    logic                   sender_ok, is_dup, in_bad_data, agg_full, timer_expire;
    logic [NUM_NODES-1:0]   sender_bit;
    logic [SCALAR_BITS-1:0] dbl_mod, mul_next, add_next, sum_next;

    // Operands are both below the modulus, so one conditional subtract fully reduces the sum
    function automatic logic [SCALAR_BITS-1:0] mod_fold(input logic [SCALAR_BITS:0] x);
        mod_fold = (x >= MOD_W) ? SCALAR_BITS'(x - MOD_W) : x[SCALAR_BITS-1:0];
    endfunction

    assign idle_like       = (state == IDLE) || (state == DONE);
    assign busy            = !idle_like;
    assign share_out_valid = (state == EVAL_OUT);
    assign share_in_ready  = (state == AGG);
    assign agg_done        = (state == DONE);
    assign share_out_idx   = share_out_valid ? j   : 8'd0;
    assign share_out_data  = share_out_valid ? acc : '0;

    assign out_hs       = share_out_valid && share_out_ready;
    assign in_hs        = share_in_valid && share_in_ready;
    assign sender_ok    = (share_in_sender != 8'd0) && (share_in_sender <= LAST_J);
    assign sender_bit   = NUM_NODES'(1) << (share_in_sender - 8'd1);
    assign is_dup       = |(recv_mask & sender_bit);
    assign in_bad_data  = (share_in_data >= MODULUS);
    assign agg_full     = &(recv_mask | complaint_mask);
    assign timer_expire = !in_hs && (timer == TIMER_END);

    // One MSB-first double-and-add step of r = acc * j, plus the Horner coefficient add
    assign dbl_mod  = mod_fold({r, 1'b0});
    assign mul_next = j[bit_cnt] ? mod_fold({1'b0, dbl_mod} + {1'b0, acc}) : dbl_mod;
    assign add_next = mod_fold({1'b0, r} + {1'b0, coeff[k]});
    assign sum_next = mod_fold({1'b0, acc_sum} + {1'b0, share_in_data});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; abort overrides everything, eval start beats agg start
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_eval)     state_next = EVAL_LOAD;
                    else if (start_agg) state_next = AGG;
                end
                EVAL_LOAD: state_next = EVAL_MUL;
                EVAL_MUL:  if (bit_cnt == 3'd0) state_next = EVAL_ADD;
                EVAL_ADD:  state_next = (k == '0) ? EVAL_OUT : EVAL_MUL;
                EVAL_OUT:  if (out_hs) state_next = (j == LAST_J) ? IDLE : EVAL_LOAD;
                AGG:       if (agg_full || timer_expire) state_next = DONE;
                default:   state_next = IDLE;
            endcase
        end
    end

    // Coefficient RAM: only accepts in-range indices and reduced values while not busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= THRESHOLD; i++) coeff[i] <= '0;
        end else if (coeff_wr_en && idle_like && (coeff_wr_idx <= T_IDX)
                     && (coeff_wr_data < MODULUS)) begin
            coeff[coeff_wr_idx[KW-1:0]] <= coeff_wr_data;
        end
    end

    // Evaluation and aggregation datapath, masks, sticky errors and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc            <= '0;
            r              <= '0;
            acc_sum        <= '0;
            j              <= 8'd0;
            k              <= '0;
            bit_cnt        <= 3'd0;
            timer          <= '0;
            recv_mask      <= '0;
            complaint_mask <= '0;
            err            <= 4'd0;
            secret_share   <= '0;
            eval_done      <= 1'b0;
        end else begin
            eval_done <= 1'b0;
            if (!abort) begin
                case (state)
                    IDLE, DONE: begin
                        if (coeff_wr_en && (coeff_wr_data >= MODULUS)) err[3] <= 1'b1;
                        if (start_eval) begin
                            j <= 8'd1;
                        end else if (start_agg) begin
                            acc_sum        <= '0;
                            recv_mask      <= '0;
                            complaint_mask <= '0;
                            err[2:0]       <= 3'd0;
                            timer          <= '0;
                        end
                    end
                    EVAL_LOAD: begin
                        acc     <= coeff[THRESHOLD];
                        k       <= K_TOP;
                        r       <= '0;
                        bit_cnt <= 3'd7;
                    end
                    EVAL_MUL: begin
                        r       <= mul_next;
                        bit_cnt <= bit_cnt - 3'd1;
                    end
                    EVAL_ADD: begin
                        acc <= add_next;
                        if (k != '0) begin
                            k       <= k - KW'(1);
                            r       <= '0;
                            bit_cnt <= 3'd7;
                        end
                    end
                    EVAL_OUT: begin
                        if (out_hs) begin
                            if (j == LAST_J) eval_done <= 1'b1;
                            else             j <= j + 8'd1;
                        end
                    end
                    AGG: begin
                        if (in_hs) begin
                            timer <= '0;
                            if (!sender_ok)       err[1] <= 1'b1;
                            else if (is_dup)      err[2] <= 1'b1;
                            else if (in_bad_data) complaint_mask <= complaint_mask | sender_bit;
                            else begin
                                acc_sum   <= sum_next;
                                recv_mask <= recv_mask | sender_bit;
                            end
                        end else begin
                            timer <= timer + 32'd1;
                        end
                        if (timer_expire && !agg_full) err[0] <= 1'b1;
                        if (agg_full || timer_expire)  secret_share <= acc_sum;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frost_share_engine.sv
// tb/tb_frost_share_engine.sv - self-checking bench for frost_share_engine (L=97, 4 nodes, t=2)
module tb_frost_share_engine;

    localparam int N  = 4;
    localparam int T  = 2;
    localparam int SB = 7;
    localparam int TO = 20;
    localparam int L  = 97;

    logic          clk, rst_n, start_eval, start_agg, abort;
    logic          coeff_wr_en;
    logic [7:0]    coeff_wr_idx;
    logic [SB-1:0] coeff_wr_data;
    logic          share_out_valid, share_out_ready;
    logic [7:0]    share_out_idx;
    logic [SB-1:0] share_out_data;
    logic          share_in_valid, share_in_ready;
    logic [7:0]    share_in_sender;
    logic [SB-1:0] share_in_data;
    logic          busy, eval_done, agg_done;
    logic [SB-1:0] secret_share;
    logic [N-1:0]  recv_mask, complaint_mask;
    logic [3:0]    err;

    frost_share_engine #(
        .NUM_NODES(N), .THRESHOLD(T), .SCALAR_BITS(SB), .MODULUS(7'd97), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_eval(start_eval), .start_agg(start_agg), .abort(abort),
        .coeff_wr_en(coeff_wr_en), .coeff_wr_idx(coeff_wr_idx), .coeff_wr_data(coeff_wr_data),
        .share_out_valid(share_out_valid), .share_out_ready(share_out_ready),
        .share_out_idx(share_out_idx), .share_out_data(share_out_data),
        .share_in_valid(share_in_valid), .share_in_ready(share_in_ready),
        .share_in_sender(share_in_sender), .share_in_data(share_in_data),
        .busy(busy), .eval_done(eval_done), .agg_done(agg_done), .secret_share(secret_share),
        .recv_mask(recv_mask), .complaint_mask(complaint_mask), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]       c0, c1, c2;
        logic [2:0]       hold_j;
        logic [3:0][7:0]  ex;
    } evec_t;

    typedef struct {
        int snd;
        int dat;
    } share_t;

    int     total = 0;
    int     bad = 0;
    int     done_cnt = 0;
    int     got_idx [5];
    int     got_data [5];
    int     got_lat [5];
    int     got_done;
    share_t txq [16];
    int     txn;
    evec_t  vt [4];

    always @(negedge clk) if (rst_n && eval_done) done_cnt = done_cnt + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int f_model(input int c0, input int c1, input int c2, input int x);
        longint s;
        s = longint'(c0) + longint'(c1) * x + longint'(c2) * x * x;
        return int'(s % L);
    endfunction

    // Applies the aggregation rules to txq; stops at the share that completes the masks
    task automatic agg_model(output int n_send, output int sum, output int rm,
                             output int cm, output int e);
        int full;
        full = (1 << N) - 1;
        sum = 0; rm = 0; cm = 0; e = 0; n_send = txn;
        for (int i = 0; i < txn; i++) begin
            if ((rm | cm) == full) begin
                n_send = i;
                break;
            end
            if (txq[i].snd < 1 || txq[i].snd > N)       e = e | 2;
            else if (((rm >> (txq[i].snd - 1)) & 1) != 0) e = e | 4;
            else if (txq[i].dat >= L)                    cm = cm | (1 << (txq[i].snd - 1));
            else begin
                sum = (sum + txq[i].dat) % L;
                rm  = rm | (1 << (txq[i].snd - 1));
            end
        end
        if ((rm | cm) != full) e = e | 1;
    endtask

    task automatic write_coeff(input int idx, input int d);
        coeff_wr_en   = 1'b1;
        coeff_wr_idx  = 8'(idx);
        coeff_wr_data = SB'(d);
        @(negedge clk);
        coeff_wr_en = 1'b0;
    endtask

    task automatic run_eval(input int c0, input int c1, input int c2, input bit do_write,
                            input int hold_j);
        int d0, lat;
        if (do_write) begin
            write_coeff(0, c0);
            write_coeff(1, c1);
            write_coeff(2, c2);
        end
        start_eval = 1'b1;
        @(negedge clk);
        start_eval = 1'b0;
        d0 = done_cnt;
        for (int jj = 1; jj <= N; jj++) begin
            lat = 0;
            while (!share_out_valid && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            got_lat[jj]  = lat;
            got_idx[jj]  = int'(share_out_idx);
            got_data[jj] = int'(share_out_data);
            if (jj == hold_j) begin
                share_out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("hold_valid", share_out_valid, 1);
                    chk("hold_idx", share_out_idx, jj);
                    chk("hold_data", share_out_data, got_data[jj]);
                end
                share_out_ready = 1'b1;
            end
            @(negedge clk);
        end
        repeat (2) @(negedge clk);
        got_done = done_cnt - d0;
    endtask

    task automatic check_eval(input int e1, input int e2, input int e3, input int e4);
        int ex [5];
        ex[1] = e1; ex[2] = e2; ex[3] = e3; ex[4] = e4;
        for (int jj = 1; jj <= N; jj++) begin
            chk("share_idx", got_idx[jj], jj);
            chk("share_data", got_data[jj], ex[jj]);
            chk("share_latency", got_lat[jj], 1 + 9 * T);
        end
        chk("eval_done_count", got_done, 1);
        chk("busy_after_eval", busy, 0);
    endtask

    task automatic run_agg(input int err3);
        int n_send, sum, rm, cm, e, cnt;
        agg_model(n_send, sum, rm, cm, e);
        start_agg = 1'b1;
        @(negedge clk);
        start_agg = 1'b0;
        chk("agg_ready", share_in_ready, 1);
        for (int i = 0; i < n_send; i++) begin
            share_in_valid  = 1'b1;
            share_in_sender = 8'(txq[i].snd);
            share_in_data   = SB'(txq[i].dat);
            @(negedge clk);
        end
        share_in_valid = 1'b0;
        cnt = 0;
        while (!agg_done && cnt < 80) begin
            @(negedge clk);
            cnt++;
        end
        chk("agg_done", agg_done, 1);
        chk("secret_share", secret_share, sum);
        chk("recv_mask", recv_mask, rm);
        chk("complaint_mask", complaint_mask, cm);
        chk("err", err, e | (err3 << 3));
        chk("agg_ready_done", share_in_ready, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #3000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int n_s, s_sum, s_rm, s_cm, s_e, c0, c1, c2, d0;
        vt[0] = '{c0: 8'd5,  c1: 8'd3,  c2: 8'd2,  hold_j: 3'd0, ex: {8'd49, 8'd32, 8'd19, 8'd10}};
        vt[1] = '{c0: 8'd90, c1: 8'd50, c2: 8'd40, hold_j: 3'd2, ex: {8'd57, 8'd18, 8'd59, 8'd83}};
        vt[2] = '{c0: 8'd0,  c1: 8'd0,  c2: 8'd0,  hold_j: 3'd0, ex: {8'd0,  8'd0,  8'd0,  8'd0}};
        vt[3] = '{c0: 8'd96, c1: 8'd96, c2: 8'd96, hold_j: 3'd4, ex: {8'd76, 8'd84, 8'd90, 8'd94}};

        rst_n = 1'b0; start_eval = 1'b0; start_agg = 1'b0; abort = 1'b0;
        coeff_wr_en = 1'b0; coeff_wr_idx = 8'd0; coeff_wr_data = '0;
        share_out_ready = 1'b1; share_in_valid = 1'b0; share_in_sender = 8'd0; share_in_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", share_out_valid, 0);
        chk("rst_in_ready", share_in_ready, 0);
        chk("rst_agg_done", agg_done, 0);
        chk("rst_err", err, 0);
        chk("rst_secret", secret_share, 0);
        chk("rst_masks", {recv_mask, complaint_mask}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            run_eval(int'(vt[v].c0), int'(vt[v].c1), int'(vt[v].c2), 1'b1, int'(vt[v].hold_j));
            check_eval(int'(vt[v].ex[0]), int'(vt[v].ex[1]), int'(vt[v].ex[2]), int'(vt[v].ex[3]));
        end

        for (int it = 0; it < 4; it++) begin
            c0 = $urandom_range(0, L - 1);
            c1 = $urandom_range(0, L - 1);
            c2 = $urandom_range(0, L - 1);
            run_eval(c0, c1, c2, 1'b1, 0);
            check_eval(f_model(c0, c1, c2, 1), f_model(c0, c1, c2, 2),
                       f_model(c0, c1, c2, 3), f_model(c0, c1, c2, 4));
        end

        txn = 4;
        txq[0] = '{1, 50}; txq[1] = '{2, 60}; txq[2] = '{3, 70}; txq[3] = '{4, 80};
        run_agg(0);
        chk("agg_all_secret", secret_share, 66);
        chk("agg_all_recv", recv_mask, 4'b1111);

        txn = 6;
        txq[0] = '{1, 10}; txq[1] = '{2, 20}; txq[2] = '{2, 30};
        txq[3] = '{5, 40}; txq[4] = '{3, 100}; txq[5] = '{4, 50};
        run_agg(0);
        chk("agg_err_secret", secret_share, 80);
        chk("agg_err_complaint", complaint_mask, 4'b0100);
        chk("agg_err_bits", err, 4'b0110);

        start_agg = 1'b1;
        @(negedge clk);
        start_agg = 1'b0;
        for (int s = 1; s <= 3; s++) begin
            share_in_valid = 1'b1; share_in_sender = 8'(s); share_in_data = SB'(s);
            @(negedge clk);
        end
        share_in_valid = 1'b0;
        repeat (19) @(negedge clk);
        chk("timeout_not_early", agg_done, 0);
        @(negedge clk);
        chk("timeout_done", agg_done, 1);
        chk("timeout_err", err, 4'b0001);
        chk("timeout_recv", recv_mask, 4'b0111);
        chk("timeout_secret", secret_share, 6);

        for (int it = 0; it < 5; it++) begin
            txn = $urandom_range(1, 9);
            for (int i = 0; i < txn; i++) begin
                txq[i].snd = $urandom_range(0, N + 1);
                txq[i].dat = $urandom_range(0, 110);
            end
            run_agg(0);
        end

        write_coeff(0, 5); write_coeff(1, 3); write_coeff(2, 2);
        d0 = done_cnt;
        start_eval = 1'b1; start_agg = 1'b1;
        @(negedge clk);
        start_eval = 1'b0; start_agg = 1'b0;
        chk("both_start_busy", busy, 1);
        chk("both_start_no_agg", share_in_ready, 0);
        coeff_wr_en = 1'b1; coeff_wr_idx = 8'd0; coeff_wr_data = SB'(1);
        @(negedge clk);
        coeff_wr_en = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_eval_busy", busy, 0);
        chk("abort_eval_valid", share_out_valid, 0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        run_eval(0, 0, 0, 1'b0, 0);
        check_eval(10, 19, 32, 49);

        start_agg = 1'b1;
        @(negedge clk);
        start_agg = 1'b0;
        share_in_valid = 1'b1; share_in_sender = 8'd1; share_in_data = SB'(5);
        @(negedge clk);
        share_in_valid = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_agg_ready", share_in_ready, 0);
        chk("abort_agg_busy", busy, 0);
        chk("abort_agg_done", agg_done, 0);
        chk("abort_agg_mask_kept", recv_mask, 4'b0001);

        d0 = done_cnt;
        start_eval = 1'b1;
        @(negedge clk);
        start_eval = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_valid", share_out_valid, 0);
        chk("midrst_mask", recv_mask, 0);
        chk("midrst_eval_done", eval_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_no_done", done_cnt - d0, 0);
        run_eval(0, 0, 0, 1'b0, 0);
        check_eval(0, 0, 0, 0);

        run_eval(5, 3, 2, 1'b1, 0);
        check_eval(10, 19, 32, 49);
        write_coeff(0, 100);
        chk("coeff_range_err", err, 4'b1000);
        run_eval(0, 0, 0, 1'b0, 0);
        check_eval(10, 19, 32, 49);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frost_share_engine.md
FROST_SHARE_ENGINE -- requirements
Module: frost_share_engine

Interface
REQ-001 Parameters SHALL be: NUM_NODES, default 4, participant count (2..255); THRESHOLD, default 2, polynomial degree t (1..NUM_NODES-1); SCALAR_BITS, default 253, scalar width; MODULUS, default 253'h1000000000000000000000000000000014def9dea2f79cd65812631a5cf5d3ed, group order L (MODULUS < 2^SCALAR_BITS); TIMEOUT_CYCLES, default 65535, aggregation idle limit.
REQ-002 Ports SHALL be: clk in 1, sole clock; rst_n in 1, asynchronous active-low reset; start_eval in 1; start_agg in 1; abort in 1, synchronous return to IDLE.
REQ-003 Coefficient ports SHALL be: coeff_wr_en in 1; coeff_wr_idx in 8; coeff_wr_data in SCALAR_BITS.
REQ-004 Share-out ports SHALL be: share_out_valid out 1; share_out_ready in 1; share_out_idx out 8, recipient j; share_out_data out SCALAR_BITS, f(j).
REQ-005 Share-in ports SHALL be: share_in_valid in 1; share_in_ready out 1; share_in_sender in 8, 1..NUM_NODES; share_in_data in SCALAR_BITS.
REQ-006 Status ports SHALL be: busy out 1; eval_done out 1, pulse; agg_done out 1, level; secret_share out SCALAR_BITS; recv_mask out NUM_NODES; complaint_mask out NUM_NODES; err out 4, sticky {coeff_range, dup, sender_range, timeout}.

Function
REQ-007 States SHALL be IDLE, EVAL_LOAD, EVAL_MUL, EVAL_ADD, EVAL_OUT, AGG, DONE; busy = state not IDLE and not DONE.
REQ-008 Coefficient RAM a[0..THRESHOLD] SHALL be written only in IDLE/DONE; writes while busy, idx > THRESHOLD ignored; data >= MODULUS ignored and err[3] set.
REQ-009 start_eval in IDLE/DONE SHALL go to EVAL_LOAD with j=1; if start_eval and start_agg both high, eval wins, start_agg dropped.
REQ-010 EVAL_LOAD (1 cycle): acc <= a[THRESHOLD], k <= THRESHOLD-1, to EVAL_MUL.
REQ-011 EVAL_MUL: 8 cycles, MSB-first over j[7:0]: r <= 2r mod M, then +acc mod M if bit set; each step one conditional subtract; to EVAL_ADD.
REQ-012 EVAL_ADD (1 cycle): acc <= (r + a[k]) mod M; k=0 -> EVAL_OUT, else k-1, EVAL_MUL.
REQ-013 Latency: start_eval sampled at edge N -> share_out_valid high after edge N+1+9*THRESHOLD for j=1; same spacing after each handshake.
REQ-014 EVAL_OUT: share_out_valid high, idx/data stable until share_out_ready; on handshake j+1 -> EVAL_LOAD, or after j=NUM_NODES: eval_done one-cycle pulse, -> IDLE.
REQ-015 start_agg in IDLE/DONE SHALL clear acc_sum, recv_mask, complaint_mask, err[2:0], agg_done, timer; enter AGG.
REQ-016 AGG: share_in_ready=1; on valid&ready: sender 0 or >NUM_NODES -> err[1], discard; sender bit in recv_mask -> err[2], discard; data >= M -> set complaint_mask bit, discard; else acc_sum <= (acc_sum+data) mod M, set recv_mask bit.
REQ-017 Timer SHALL reset on each handshake, increment otherwise; reaching TIMEOUT_CYCLES -> err[0], DONE.
REQ-018 recv_mask|complaint_mask all ones SHALL go to DONE the cycle after the final handshake; DONE: agg_done=1, secret_share=acc_sum, share_in_ready=0.
REQ-019 abort SHALL return to IDLE next edge from any state, drop share_out_valid/share_in_ready, no done pulse; masks/err retained.
REQ-020 All modular results SHALL be < MODULUS; internal sums SCALAR_BITS+1 wide.

Reset
REQ-021 rst_n low SHALL asynchronously force IDLE; all outputs, acc, timer, masks, err, secret_share 0; coefficient RAM 0.
REQ-022 rst_n deassertion mid-operation SHALL resume from IDLE; no pending handshake survives.

Verification (MODULUS=97, SCALAR_BITS=7, NUM_NODES=4, THRESHOLD=2)
REQ-023 a=(5,3,2), start_eval, ready=1 -> shares (1,10),(2,19),(3,32),(4,49); first valid 19 cycles after start; eval_done once.
REQ-024 a=(90,50,40) -> 83,59,18,57 (wrap); share_out_ready low 5 cycles at j=2 -> data held, no skip.
REQ-025 Agg shares 50,60,70,80 senders 1..4 -> secret_share=66, recv_mask=1111, agg_done, err=0.
REQ-026 Agg sender 2 twice, sender 5, sender 3 data 100 -> err[2], err[1] set; complaint_mask=0100; duplicate not summed.
REQ-027 Agg only 3 shares, TIMEOUT_CYCLES=20 -> DONE at 20 idle cycles, err[0], recv_mask=0111.
REQ-028 rst_n low during EVAL_MUL and abort during AGG -> outputs 0 / IDLE next edge, no eval_done; coeff write 100 -> err[3], RAM unchanged.
